axi_read_burst_master: RTL and testbench

Read-side AXI4 burst engine for the VDMA read path. It sits directly downstream of the read-FIFO status controller and takes its `burst_req`/`tail_req` with `req_len` (in beats). It issues the matching AXI4 AR transactions from a running frame address and streams R beats into the read FIFO. When a request is accepted it returns a `resp` pulse; when its last beat lands it returns a `done` pulse.

---
 rtl/axi_vdma_pkg.sv | 21 ++
 rtl/rd_burst_len_calc.sv | 31 +++
 rtl/axi_read_burst_master.sv | 143 ++++++++++++++
 tb/tb_axi_read_burst_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_vdma_pkg.sv
// Shared AXI constants and read-engine state encoding for the VDMA read path.
package axi_vdma_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam int         AXI_BOUNDARY_4K = 4096;
    localparam int         AXI_MAX_BURST   = 256;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_ADDR_ENC = 2'd1;
    localparam logic [1:0] ST_DATA_ENC = 2'd2;
    localparam logic [1:0] ST_FSH_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ADDR = ST_ADDR_ENC,
        ST_DATA = ST_DATA_ENC,
        ST_FSH  = ST_FSH_ENC
    } rd_state_t;

endpackage

// File: rtl/rd_burst_len_calc.sv
// Sub-burst length: min(remaining beats, MAX_BURST, beats left before the next 4 KB page).
module rd_burst_len_calc
    import axi_vdma_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int LSIZE      = 9,
    parameter int MAX_BURST  = AXI_MAX_BURST,
    parameter int LEN_W      = $clog2(MAX_BURST) + 1
) (
    input  logic [11:0]      page_off,
    input  logic [LSIZE-1:0] remaining,
    output logic [LEN_W-1:0] sub_len
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int CW    = (LSIZE > 13) ? LSIZE : 13;

    logic [CW-1:0] to_bound;
    logic [CW-1:0] rem_ext;
    logic [CW-1:0] lim;

    always_comb begin
        to_bound = (CW'(AXI_BOUNDARY_4K) - CW'(page_off)) >> SHIFT;
        rem_ext  = CW'(remaining);
        lim      = to_bound;
        if (lim > CW'(MAX_BURST)) lim = CW'(MAX_BURST);
        if (rem_ext < lim) lim = rem_ext;
        sub_len = LEN_W'(lim);
    end

endmodule

// File: rtl/axi_read_burst_master.sv
// AXI4 read burst engine: splits requests into 4 KB-safe AR bursts and streams R beats to the read FIFO.
// Optional read-error checking is enabled with `define AXI_RD_ERR_CHECK_EN.
module axi_read_burst_master
    import axi_vdma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int LSIZE      = 9,
    parameter int MAX_BURST  = AXI_MAX_BURST
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  fsync,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  burst_req,
    input  logic                  tail_req,
    input  logic [LSIZE-1:0]      req_len,
    output logic                  resp,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    output logic                  rd_err
);

    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam int LEN_W     = $clog2(MAX_BURST) + 1;

    rd_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LSIZE-1:0]      remaining;
    logic [LEN_W-1:0]      sub_len, sub_len_q, beat_cnt;
    logic                  fsync_pend;
    logic                  reload, take_req, ar_hs, r_hs, last_beat;

    rd_burst_len_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSIZE      (LSIZE),
        .MAX_BURST  (MAX_BURST),
        .LEN_W      (LEN_W)
    ) u_len_calc (
        .page_off  (cur_addr[11:0]),
        .remaining (remaining),
        .sub_len   (sub_len)
    );

    assign arsize       = 3'(SIZE_LOG2);
    assign arburst      = AXI_BURST_INCR;
    assign rready       = (state == ST_DATA) && !fifo_full;
    assign ar_hs        = arvalid && arready;
    assign r_hs         = rvalid && rready;
    assign fifo_wr_en   = r_hs;
    assign fifo_wr_data = rdata;
    assign last_beat    = (beat_cnt == sub_len_q - LEN_W'(1));
    // A deferred frame start is applied while leaving FSH so IDLE already sees the new base.
    assign reload       = ((state == ST_IDLE) || (state == ST_FSH)) && (fsync || fsync_pend);
    assign take_req     = (state == ST_IDLE) && !reload && (burst_req || tail_req);

    always_ff @(posedge clock) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (take_req) state_nxt = ST_ADDR;
            ST_ADDR: begin
                if (remaining == '0) state_nxt = ST_FSH;
                else if (ar_hs)      state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (r_hs && last_beat) state_nxt = (remaining == '0) ? ST_FSH : ST_ADDR;
            end
            ST_FSH:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            resp       <= 1'b0;
            done       <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            arlen      <= '0;
            cur_addr   <= '0;
            remaining  <= '0;
            beat_cnt   <= '0;
            sub_len_q  <= '0;
            fsync_pend <= 1'b0;
        end else begin
            resp <= take_req;
            done <= (state != ST_FSH) && (state_nxt == ST_FSH);
            if (reload) begin
                cur_addr   <= base_addr;
                fsync_pend <= 1'b0;
            end else if (fsync) begin
                fsync_pend <= 1'b1;
            end
            if (take_req) remaining <= req_len;
            if (state == ST_ADDR) begin
                if (!arvalid && remaining != '0) begin
                    arvalid <= 1'b1;
                    araddr  <= cur_addr;
                    arlen   <= 8'(sub_len - LEN_W'(1));
                end else if (ar_hs) begin
                    arvalid   <= 1'b0;
                    cur_addr  <= cur_addr + (ADDR_WIDTH'(sub_len) << SIZE_LOG2);
                    remaining <= remaining - LSIZE'(sub_len);
                    sub_len_q <= sub_len;
                    beat_cnt  <= '0;
                end
            end
            if (r_hs) beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

`ifdef AXI_RD_ERR_CHECK_EN
    // rlast is cross-checked against the engine's own beat count, never used to end a burst.
    always_ff @(posedge clock) begin
        if (!rst_n)     rd_err <= 1'b0;
        else if (fsync) rd_err <= 1'b0;
        else if (r_hs && ((rresp != AXI_RESP_OKAY) || (rlast != last_beat))) rd_err <= 1'b1;
    end
`else
    logic unused_r_status;
    assign unused_r_status = ^{rresp, rlast};
    assign rd_err          = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_burst_master.sv
// Directed bench for axi_read_burst_master with a cycle-level AXI read slave and FIFO model.
module tb_axi_read_burst_master;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         fsync;
    logic [31:0]  base_addr;
    logic         burst_req, tail_req;
    logic [8:0]   req_len;
    logic         resp, done;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic         fifo_full;
    logic         rd_err;

    axi_read_burst_master dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .fsync        (fsync),
        .base_addr    (base_addr),
        .burst_req    (burst_req),
        .tail_req     (tail_req),
        .req_len      (req_len),
        .resp         (resp),
        .done         (done),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .rd_err       (rd_err)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    int resp_cnt, done_cnt, wr_cnt, resp_cyc, done_cyc, last_wr_cyc;
    int full_viol, data_err, beat_idx, burst_pos;
    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];
    int          burst_q[$];
`ifdef AXI_RD_ERR_CHECK_EN
    logic exp_err = 1'b1;
`else
    logic exp_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_fsync(input logic [31:0] addr);
        base_addr = addr;
        fsync     = 1'b1;
        tick();
        fsync     = 1'b0;
        tick();
    endtask

    // One request end to end; the AXI slave answers every AR with back-to-back beats.
    task automatic run(input bit use_tail, input int len, input int full_at, input int full_len,
                       input int fsync_at, input int err_at);
        bit   ar_hs, r_hs;
        int   cyc;
        int   len_s;
        resp_cnt = 0; done_cnt = 0; wr_cnt = 0; resp_cyc = -1; done_cyc = -1; last_wr_cyc = -1;
        full_viol = 0; data_err = 0; beat_idx = 0; burst_pos = 0;
        ar_addr_q.delete(); ar_len_q.delete(); burst_q.delete();
        if (use_tail) tail_req = 1'b1;
        else          burst_req = 1'b1;
        req_len = 9'(len);
        rresp   = (err_at == 0) ? 2'b10 : 2'b00;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clock);
            if (resp) begin resp_cnt++; resp_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (fifo_full && (rready || fifo_wr_en)) full_viol++;
            if (fifo_wr_en && (fifo_wr_data !== rdata)) data_err++;
            if (fifo_wr_en) begin wr_cnt++; last_wr_cyc = cyc; end
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            len_s = int'(arlen) + 1;
            if (ar_hs) begin ar_addr_q.push_back(araddr); ar_len_q.push_back(int'(arlen)); end
            @(posedge clock);
            #1;
            if (ar_hs) burst_q.push_back(len_s);
            if (r_hs) begin
                beat_idx++;
                burst_pos++;
                if (burst_q.size() > 0 && burst_pos == burst_q[0]) begin
                    void'(burst_q.pop_front());
                    burst_pos = 0;
                end
            end
            if (resp_cnt > 0) begin burst_req = 1'b0; tail_req = 1'b0; end
            cyc++;
            rvalid    = (burst_q.size() > 0);
            rlast     = rvalid && (burst_pos == burst_q[0] - 1);
            rdata     = {4{beat_idx ^ 32'h5a5a_0000}};
            rresp     = (beat_idx == err_at) ? 2'b10 : 2'b00;
            fifo_full = (cyc >= full_at) && (cyc < full_at + full_len);
            fsync     = (cyc == fsync_at);
            if (done_cnt > 0 && cyc > done_cyc + 2) break;
        end
        burst_req = 1'b0; tail_req = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rresp = 2'b00; fifo_full = 1'b0; fsync = 1'b0;
        check("run_completed", 64'(done_cnt > 0), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; fsync = 1'b0; base_addr = '0; burst_req = 1'b0; tail_req = 1'b0;
        req_len = '0; arready = 1'b1; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        rvalid = 1'b0; fifo_full = 1'b0;
        repeat (3) tick();
        check("rst_resp", 64'(resp), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_rd_err", 64'(rd_err), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_arlen", 64'(arlen), 64'd0);
        check("arsize", 64'(arsize), 64'd4);
        check("arburst", 64'(arburst), 64'd1);
        rst_n = 1'b1;
        tick();

        // 200 beats inside one page
        pulse_fsync(32'h1000_0000);
        run(1'b0, 200, 9999, 0, -1, -1);
        check("b200_resp_cnt", 64'(resp_cnt), 64'd1);
        check("b200_done_cnt", 64'(done_cnt), 64'd1);
        check("b200_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
        check("b200_araddr", 64'(ar_addr_q[0]), 64'h1000_0000);
        check("b200_arlen", 64'(ar_len_q[0]), 64'd199);
        check("b200_writes", 64'(wr_cnt), 64'd200);
        check("b200_done_timing", 64'(done_cyc), 64'(last_wr_cyc + 1));
        check("b200_data", 64'(data_err), 64'd0);

        // 200 beats crossing the 4 KB page at 0x1000_1000
        run(1'b0, 200, 9999, 0, -1, -1);
        check("split_ar_cnt", 64'(ar_addr_q.size()), 64'd2);
        check("split_addr0", 64'(ar_addr_q[0]), 64'h1000_0C80);
        check("split_len0", 64'(ar_len_q[0]), 64'd55);
        check("split_addr1", 64'(ar_addr_q[1]), 64'h1000_1000);
        check("split_len1", 64'(ar_len_q[1]), 64'd143);
        check("split_resp_cnt", 64'(resp_cnt), 64'd1);
        check("split_done_cnt", 64'(done_cnt), 64'd1);
        check("split_writes", 64'(wr_cnt), 64'd200);

        // tail request of 511 beats from a page-aligned base
        pulse_fsync(32'h2000_0000);
        run(1'b1, 511, 9999, 0, -1, -1);
        check("tail_ar_cnt", 64'(ar_addr_q.size()), 64'd2);
        check("tail_len0", 64'(ar_len_q[0]), 64'd255);
        check("tail_addr1", 64'(ar_addr_q[1]), 64'h2000_1000);
        check("tail_len1", 64'(ar_len_q[1]), 64'd254);
        check("tail_writes", 64'(wr_cnt), 64'd511);
        check("tail_done_timing", 64'(done_cyc), 64'(last_wr_cyc + 1));

        // single beat: one beat left before the page end, minimum latency
        run(1'b0, 1, 9999, 0, -1, -1);
        check("one_araddr", 64'(ar_addr_q[0]), 64'h2000_1FF0);
        check("one_arlen", 64'(ar_len_q[0]), 64'd0);
        check("one_resp_cyc", 64'(resp_cyc), 64'd1);
        check("one_done_cyc", 64'(done_cyc), 64'd4);

        // FIFO back-pressure for 10 cycles mid-burst
        run(1'b0, 100, 20, 10, -1, -1);
        check("full_araddr", 64'(ar_addr_q[0]), 64'h2000_2000);
        check("full_no_write", 64'(full_viol), 64'd0);
        check("full_writes", 64'(wr_cnt), 64'd100);
        check("full_done_cnt", 64'(done_cnt), 64'd1);

        // frame start during DATA: current burst completes at the old address
        base_addr = 32'h3000_0000;
        run(1'b0, 64, 9999, 0, 10, -1);
        check("fs_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
        check("fs_old_addr", 64'(ar_addr_q[0]), 64'h2000_2640);
        check("fs_writes", 64'(wr_cnt), 64'd64);
        run(1'b0, 1, 9999, 0, -1, -1);
        check("fs_new_addr", 64'(ar_addr_q[0]), 64'h3000_0000);

        // zero-length request: no AXI traffic, resp and done still pulse
        run(1'b0, 0, 9999, 0, -1, -1);
        check("zero_resp_cnt", 64'(resp_cnt), 64'd1);
        check("zero_done_cnt", 64'(done_cnt), 64'd1);
        check("zero_ar_cnt", 64'(ar_addr_q.size()), 64'd0);
        check("zero_writes", 64'(wr_cnt), 64'd0);
        check("clean_rd_err", 64'(rd_err), 64'd0);

        // SLVERR on the second beat
        run(1'b0, 4, 9999, 0, -1, 1);
        check("err_set", 64'(rd_err), 64'(exp_err));
        run(1'b0, 1, 9999, 0, -1, -1);
        check("err_sticky", 64'(rd_err), 64'(exp_err));
        pulse_fsync(32'h4000_0000);
        check("err_cleared", 64'(rd_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
